palette_fader: RTL and testbench
================================

Name: palette_fader

Overview:
- Scene-transition controller in front of the palette lookup: owns the 3-bit palette bank select and fades the looked-up 24-bit colour to black and back.
- Sits between the colour mapper (drives the palette select and consumes the 24-bit colour) and the VGA output register.
- Game FSM requests a scene bank; the fader sequences fade-out -> bank swap -> hold -> fade-in.
- Fade level changes only on frame boundaries, so there is no tearing.

Parameters:
STEP_FRAMES, 4, frame_tick pulses per fade level step (>=1)
HOLD_FRAMES, 2, frame_tick pulses held fully black after the swap (>=1)
RESET_SEL, 3, palette bank selected out of reset (start screen)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high
frame_tick  in  1  single-cycle pulse at start of vblank
scene_req  in  1  request a bank change; held until scene_ack
scene_sel  in  3  requested bank (0 sprite, 1 map, 2 gym, 3 start)
scene_ack  out  1  one-cycle pulse: request accepted
in_color  in  24  colour from palette lookup, {R,G,B}
out_color  out  24  faded colour, registered
palette_select  out  3  bank select driven to the palette lookup
fade_level  out  4  current brightness, 0..8
busy  out  1  high in any state except IDLE
swap_pulse  out  1  one-cycle pulse when palette_select changes (game logic reloads map/sprites)
done  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset values:
  - palette_select=RESET_SEL, fade_level=8, out_color=0.
  - scene_ack=0, busy=0, swap_pulse=0, done=0.
  - state=IDLE, frame counter=0, pending sel=0.
- Reset mid-transition aborts immediately to these values; no done pulse.
- States: IDLE, FADE_OUT, SWAP, HOLD, FADE_IN.
- IDLE:
  - On scene_req=1, latch scene_sel into pending and pulse scene_ack the next cycle.
  - Next state is FADE_OUT, with the frame counter cleared.
  - A frame_tick in the accepting cycle is not counted.
- Same-bank request (scene_sel==palette_select) is still acked, but skips the fade: IDLE -> IDLE, done pulses the cycle after ack, no swap_pulse.
- scene_req while busy is ignored (no ack); the requester keeps holding it.
- FADE_OUT:
  - Each frame_tick increments the counter.
  - When the counter reaches STEP_FRAMES-1 on a tick, it clears and fade_level decrements.
  - Transition to SWAP on the tick that makes fade_level 0.
- SWAP (exactly one cycle):
  - palette_select<=pending; swap_pulse=1 in this cycle; counter cleared.
  - Next state is HOLD.
- HOLD: fade_level stays 0; after HOLD_FRAMES ticks, go to FADE_IN, counter cleared.
- FADE_IN:
  - Same step rule as FADE_OUT, but fade_level increments.
  - On the tick that makes it 8: next state IDLE, done pulses the following cycle.
- Full transition length in ticks: 8*STEP_FRAMES + HOLD_FRAMES + 8*STEP_FRAMES.
- Colour scaling (1-cycle latency):
  - Per channel: out = (in_ch * fade_level) >> 3.
  - Product is 8b x 4b -> 12b; take bits [10:3].
  - Level 8 passes through exactly; level 0 gives 0x000000.
  - Registered every cycle regardless of state. out_color at cycle n+1 uses in_color and fade_level of cycle n.
- Bank values 4..7 are accepted and driven out unchanged; the palette returns black for them.
- frame_tick outside FADE_OUT/HOLD/FADE_IN has no effect.

Decomposition:
- Shared package palette_pkg:
  - Bank select constants SEL_SPRITE=3'd0, SEL_MAP=3'd1, SEL_GYM=3'd2, SEL_START=3'd3.
  - MAX_LEVEL=4'd8.
  - fade_state_t enum {IDLE, FADE_OUT, SWAP, HOLD, FADE_IN}.
- Sub-module color_scaler: combinational per-channel multiply/shift on three channels plus the output register. Instantiated once; the FSM and counters stay in palette_fader.

Test Plan:
- Reset with no requests, in_color=24'hf8d124 -> out_color=24'hf8d124 one cycle later; palette_select=3, fade_level=8, busy=0.
- STEP_FRAMES=1, HOLD_FRAMES=1; scene_req with sel=1 and ticks every 10 cycles:
  - ack pulse, then fade_level steps 8->7->...->0 on successive ticks.
  - swap_pulse with palette_select=1.
  - 1 tick hold, then 0->8, done pulse; total 17 ticks; busy high throughout.
- Scaling check: in_color=24'hffffff at fade_level=4 -> 24'h7f7f7f; at level 1 -> 24'h1f1f1f; at level 0 -> 24'h000000.
- scene_req sel=2 asserted during FADE_OUT -> no ack until done. Held request is then acked the cycle after done and a second transition runs to palette_select=2.
- Same-bank request sel=3 from reset -> scene_ack, then done the next cycle; fade_level stays 8, no swap_pulse.
- Reset asserted in HOLD (fade_level=0) -> next cycle fade_level=8, palette_select=3, busy=0, no done.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared definitions for the palette fader: bank select encodings, the
// full-brightness level, the fader state type and the per-channel
// brightness scaling helper.
package palette_pkg;

  localparam logic [2:0] SEL_SPRITE = 3'd0;
  localparam logic [2:0] SEL_MAP    = 3'd1;
  localparam logic [2:0] SEL_GYM    = 3'd2;
  localparam logic [2:0] SEL_START  = 3'd3;

  // Brightness runs 0 (black) .. MAX_LEVEL (untouched colour).
  localparam logic [3:0] MAX_LEVEL  = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_OUT = 3'd1,
    SWAP     = 3'd2,
    HOLD     = 3'd3,
    FADE_IN  = 3'd4
  } fade_state_t;

  // level/8 brightness on one 8-bit channel. Bits [10:3] of the 12-bit
  // product: at level 8 the product is ch<<3 so the channel passes exactly.
  function automatic logic [7:0] scale_channel(input logic [7:0] ch,
                                               input logic [3:0] level);
    logic [11:0] prod;
    prod = {4'd0, ch} * {8'd0, level};
    return prod[10:3];
  endfunction

endpackage

// File: rtl/palette_fader_color_scaler.sv
// color_scaler: scales a {R,G,B} colour by fade_level/8 and registers it.
// Ports:
//   Clk, Reset  - clock, synchronous active-high reset (clears out_color)
//   in_color    - 24-bit colour from the palette lookup
//   fade_level  - brightness 0..8
//   out_color   - registered scaled colour, one cycle after its inputs
module color_scaler
  import palette_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [23:0] in_color,
  input  logic [3:0]  fade_level,
  output logic [23:0] out_color
);

  logic [23:0] scaled_s;

  // Per-channel brightness scaling.
  always_comb begin
    scaled_s = {scale_channel(in_color[23:16], fade_level),
                scale_channel(in_color[15:8],  fade_level),
                scale_channel(in_color[7:0],   fade_level)};
  end

  // Output register, loaded every cycle independent of the fader state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_color <= 24'd0;
    end else begin
      out_color <= scaled_s;
    end
  end

endmodule

// File: rtl/palette_fader.sv
// palette_fader: scene-transition controller in front of the palette lookup.
// Accepts a bank request, fades the colour out over frame ticks, swaps the
// palette bank, holds black, then fades back in.
// Ports:
//   Clk, Reset     - clock, synchronous active-high reset
//   frame_tick     - one-cycle pulse at start of vblank
//   scene_req/sel  - bank request (held until scene_ack) and requested bank
//   scene_ack      - one-cycle pulse: request accepted
//   in_color       - colour from palette lookup; out_color - faded, registered
//   palette_select - bank select to the palette lookup
//   fade_level     - current brightness 0..8
//   busy           - high whenever not IDLE
//   swap_pulse     - one-cycle pulse in the bank-swap cycle
//   done           - one-cycle pulse on return to IDLE
module palette_fader
  import palette_pkg::*;
#(
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned HOLD_FRAMES = 2,
  parameter logic [2:0]  RESET_SEL   = SEL_START
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        scene_req,
  input  logic [2:0]  scene_sel,
  output logic        scene_ack,
  input  logic [23:0] in_color,
  output logic [23:0] out_color,
  output logic [2:0]  palette_select,
  output logic [3:0]  fade_level,
  output logic        busy,
  output logic        swap_pulse,
  output logic        done
);

  localparam logic [15:0] STEP_LAST = 16'(STEP_FRAMES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);

  fade_state_t state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [3:0]  level_r, level_s;
  logic [2:0]  sel_r, sel_s;
  logic [2:0]  pend_r, pend_s;
  logic        ack_r, ack_s;
  logic        done_r, done_s;
  // Same-bank request accepted last cycle: done follows without any fade.
  logic        same_r, same_s;

  // State and control registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      level_r <= MAX_LEVEL;
      sel_r   <= RESET_SEL;
      pend_r  <= 3'd0;
      ack_r   <= 1'b0;
      done_r  <= 1'b0;
      same_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      level_r <= level_s;
      sel_r   <= sel_s;
      pend_r  <= pend_s;
      ack_r   <= ack_s;
      done_r  <= done_s;
      same_r  <= same_s;
    end
  end

  // Next-state, counter and level sequencing.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    level_s = level_r;
    sel_s   = sel_r;
    pend_s  = pend_r;
    ack_s   = 1'b0;
    done_s  = 1'b0;
    same_s  = 1'b0;
    case (state_r)
      IDLE: begin
        done_s = same_r;
        // Ignore the still-held request while its ack/done is in flight.
        if (scene_req && !ack_r && !same_r) begin
          pend_s = scene_sel;
          ack_s  = 1'b1;
          cnt_s  = 16'd0;
          if (scene_sel == sel_r) begin
            same_s = 1'b1;
          end else begin
            state_s = FADE_OUT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FADE_OUT: begin
        if (frame_tick) begin
          if (cnt_r == STEP_LAST) begin
            cnt_s   = 16'd0;
            level_s = level_r - 4'd1;
            if (level_r == 4'd1) begin
              state_s = SWAP;
            end else begin
              state_s = FADE_OUT;
            end
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      SWAP: begin
        sel_s   = pend_r;
        cnt_s   = 16'd0;
        state_s = HOLD;
      end
      HOLD: begin
        if (frame_tick) begin
          if (cnt_r == HOLD_LAST) begin
            cnt_s   = 16'd0;
            state_s = FADE_IN;
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      FADE_IN: begin
        if (frame_tick) begin
          if (cnt_r == STEP_LAST) begin
            cnt_s   = 16'd0;
            level_s = level_r + 4'd1;
            if (level_r == (MAX_LEVEL - 4'd1)) begin
              state_s = IDLE;
              done_s  = 1'b1;
            end else begin
              state_s = FADE_IN;
            end
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign scene_ack      = ack_r;
  assign done           = done_r;
  assign palette_select = sel_r;
  assign fade_level     = level_r;
  assign busy           = (state_r != IDLE);
  assign swap_pulse     = (state_r == SWAP);

  color_scaler u_color_scaler (
    .Clk        (Clk),
    .Reset      (Reset),
    .in_color   (in_color),
    .fade_level (level_r),
    .out_color  (out_color)
  );

endmodule

// File: tb/tb_palette_fader.sv
// Self-checking bench for palette_fader. The reference model derives the
// expected brightness from the number of frame ticks since acceptance and
// the expected colour from plain integer arithmetic.
module tb_palette_fader;

  localparam int S = 1;
  localparam int H = 1;
  localparam int TOTAL = 16 * S + H;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        scene_req = 1'b0;
  logic [2:0]  scene_sel = 3'd0;
  logic        scene_ack;
  logic [23:0] in_color = 24'd0;
  logic [23:0] out_color;
  logic [2:0]  palette_select;
  logic [3:0]  fade_level;
  logic        busy;
  logic        swap_pulse;
  logic        done;

  int total = 0;
  int bad = 0;
  int mlevel = 8;
  logic force_white = 1'b0;
  logic [2:0] cur_sel = 3'd3;

  palette_fader #(.STEP_FRAMES(S), .HOLD_FRAMES(H), .RESET_SEL(3'd3)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .scene_req(scene_req),
    .scene_sel(scene_sel), .scene_ack(scene_ack), .in_color(in_color),
    .out_color(out_color), .palette_select(palette_select),
    .fade_level(fade_level), .busy(busy), .swap_pulse(swap_pulse), .done(done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [23:0] scale(input logic [23:0] c, input int lvl);
    int r, g, b;
    r = (int'(c[23:16]) * lvl) / 8;
    g = (int'(c[15:8]) * lvl) / 8;
    b = (int'(c[7:0]) * lvl) / 8;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Brightness after n ticks of a transition.
  function automatic int exp_level(input int n);
    int m;
    if (n < 8 * S) return 8 - n / S;
    if (n < 8 * S + H) return 0;
    m = (n - 8 * S - H) / S;
    return (m > 8) ? 8 : m;
  endfunction

  // One clock with random colour; checks the registered colour afterwards.
  task automatic step(input logic tick);
    logic [23:0] cin;
    logic [23:0] exp;
    cin = force_white ? 24'hffffff : 24'($urandom);
    in_color = cin;
    frame_tick = tick;
    exp = Reset ? 24'h000000 : scale(cin, mlevel);
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    total++;
    if (out_color !== exp) begin
      bad++;
      $display("FAIL color: got %h want %h (in %h lvl %0d)", out_color, exp, cin, mlevel);
    end
  endtask

  task automatic do_accept(input logic [2:0] sel, input logic same);
    scene_req = 1'b1;
    scene_sel = sel;
    step(1'b0);
    scene_req = 1'b0;
    total++;
    if ({scene_ack, busy} !== {1'b1, !same}) begin
      bad++;
      $display("FAIL accept: got ack/busy %b%b want %b%b", scene_ack, busy, 1'b1, !same);
    end
  endtask

  task automatic run_ticks(input logic [2:0] old_sel, input logic [2:0] new_sel,
                           input int gap, input int hold_at,
                           input logic [2:0] hold_sel, input logic chk_white);
    logic [2:0] exp_sel;
    logic [23:0] wexp;
    exp_sel = old_sel;
    force_white = chk_white;
    for (int n = 1; n <= TOTAL; n++) begin
      for (int g = 1; g < gap; g++) begin
        step(1'b0);
        total++;
        if (fade_level !== 4'(mlevel)) begin
          bad++; $display("FAIL level_gap: got %0d want %0d", fade_level, mlevel);
        end
        total++;
        if ({busy, swap_pulse, done, scene_ack} !== 4'b1000) begin
          bad++; $display("FAIL flags_gap: got busy/swap/done/ack %b%b%b%b want 1000",
                          busy, swap_pulse, done, scene_ack);
        end
        total++;
        if (palette_select !== exp_sel) begin
          bad++; $display("FAIL sel_gap: got %0d want %0d", palette_select, exp_sel);
        end
        if (g == 1 && chk_white && (mlevel == 4 || mlevel == 1 || mlevel == 0)) begin
          wexp = (mlevel == 4) ? 24'h7f7f7f : (mlevel == 1) ? 24'h1f1f1f : 24'h000000;
          total++;
          if (out_color !== wexp) begin
            bad++; $display("FAIL white_scale: got %h want %h", out_color, wexp);
          end
        end
      end
      step(1'b1);
      mlevel = exp_level(n);
      total++;
      if (fade_level !== 4'(mlevel)) begin
        bad++; $display("FAIL level_tick: tick %0d got %0d want %0d", n, fade_level, mlevel);
      end
      if (n == 8 * S) begin
        total++;
        if ({swap_pulse, palette_select} !== {1'b1, old_sel}) begin
          bad++; $display("FAIL swap: got pulse %b sel %0d want 1 sel %0d",
                          swap_pulse, palette_select, old_sel);
        end
        exp_sel = new_sel;
      end else begin
        total++;
        if (swap_pulse !== 1'b0) begin
          bad++; $display("FAIL swap_extra: tick %0d got %b want 0", n, swap_pulse);
        end
      end
      total++;
      if ({done, busy, scene_ack} !== {n == TOTAL, n != TOTAL, 1'b0}) begin
        bad++; $display("FAIL done_busy: tick %0d got done/busy/ack %b%b%b", n, done, busy, scene_ack);
      end
      if (n == hold_at) begin
        scene_req = 1'b1;
        scene_sel = hold_sel;
      end
    end
    force_white = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    step(1'b0);
    step(1'b0);
    Reset = 1'b0;
    in_color = 24'hf8d124;
    @(posedge Clk);
    #1;
    total++;
    if (out_color !== 24'hf8d124) begin
      bad++; $display("FAIL reset_color: got %h want f8d124", out_color);
    end
    total++;
    if ({palette_select, fade_level, busy, scene_ack, swap_pulse, done} !== {3'd3, 4'd8, 4'b0000}) begin
      bad++; $display("FAIL reset_state: got sel %0d lvl %0d busy %b ack %b swap %b done %b",
                      palette_select, fade_level, busy, scene_ack, swap_pulse, done);
    end
  endtask

  task automatic test_same_bank;
    do_accept(3'd3, 1'b1);
    step(1'b0);
    total++;
    if ({done, swap_pulse, scene_ack, busy, fade_level} !== {4'b1000, 4'd8}) begin
      bad++; $display("FAIL same_done: got done %b swap %b ack %b busy %b lvl %0d",
                      done, swap_pulse, scene_ack, busy, fade_level);
    end
    step(1'b0);
    total++;
    if ({done, palette_select} !== {1'b0, 3'd3}) begin
      bad++; $display("FAIL same_after: got done %b sel %0d want 0 sel 3", done, palette_select);
    end
  endtask

  task automatic test_full_fade;
    do_accept(3'd1, 1'b0);
    run_ticks(3'd3, 3'd1, 10, 0, 3'd0, 1'b0);
    cur_sel = 3'd1;
  endtask

  task automatic test_scaling;
    do_accept(3'd0, 1'b0);
    run_ticks(3'd1, 3'd0, 3, 0, 3'd0, 1'b1);
    cur_sel = 3'd0;
  endtask

  task automatic test_back_to_back;
    do_accept(3'd1, 1'b0);
    run_ticks(3'd0, 3'd1, 10, 3, 3'd2, 1'b0);
    step(1'b0);
    scene_req = 1'b0;
    total++;
    if ({scene_ack, done, busy} !== 3'b101) begin
      bad++; $display("FAIL held_ack: got ack/done/busy %b%b%b want 101", scene_ack, done, busy);
    end
    run_ticks(3'd1, 3'd2, 10, 0, 3'd0, 1'b0);
    cur_sel = 3'd2;
  endtask

  task automatic test_reset_in_hold;
    do_accept(3'd0, 1'b0);
    for (int n = 1; n <= 8 * S; n++) begin
      repeat (3) step(1'b0);
      step(1'b1);
      mlevel = exp_level(n);
    end
    step(1'b0);
    total++;
    if ({busy, fade_level, palette_select} !== {1'b1, 4'd0, 3'd0}) begin
      bad++; $display("FAIL hold_entry: got busy %b lvl %0d sel %0d", busy, fade_level, palette_select);
    end
    Reset = 1'b1;
    step(1'b0);
    Reset = 1'b0;
    mlevel = 8;
    total++;
    if ({fade_level, palette_select, busy, done, swap_pulse} !== {4'd8, 3'd3, 3'b000}) begin
      bad++; $display("FAIL abort: got lvl %0d sel %0d busy %b done %b swap %b",
                      fade_level, palette_select, busy, done, swap_pulse);
    end
    step(1'b0);
    total++;
    if ({done, busy} !== 2'b00) begin
      bad++; $display("FAIL abort_after: got done %b busy %b want 00", done, busy);
    end
    cur_sel = 3'd3;
  endtask

  task automatic test_random;
    logic [2:0] nsel;
    for (int k = 0; k < 4; k++) begin
      nsel = 3'($urandom_range(0, 7));
      if (nsel == cur_sel) nsel = nsel + 3'd1;
      do_accept(nsel, 1'b0);
      run_ticks(cur_sel, nsel, int'($urandom_range(2, 9)), 0, 3'd0, 1'b0);
      cur_sel = nsel;
      repeat (int'($urandom_range(0, 3))) step(1'b1);
    end
  endtask

  initial begin
    test_reset;
    test_same_bank;
    test_full_fade;
    test_scaling;
    test_back_to_back;
    test_reset_in_hold;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
